// File: rtl/zigzag_pkg.sv
`default_nettype none
// ============================================================================
// Module  : zigzag_pkg
// Purpose : Shared types, width helpers and key decoding for the zigzag decryptor.
// Revision: 1.0
// ============================================================================
package zigzag_pkg;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    COUNT   = 3'd1,
    OFFSET  = 3'd2,
    EMIT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic int pos_w_of(input int max_chars);
    return $clog2(max_chars + 1);
  endfunction

  function automatic int row_w_of(input int max_key);
    return (max_key > 1) ? $clog2(max_key) : 1;
  endfunction

  localparam int POS_W = pos_w_of(50);
  localparam int ROW_W = row_w_of(8);

  // Keys 0/1 and out-of-range keys all collapse to a single rail (passthrough).
  function automatic logic [31:0] eff_key(input logic [31:0] key, input int max_key);
    if ((key < 32'd2) || (key > 32'(max_key)))
      return 32'd1;
    return key;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zigzag_row_walker.sv
`default_nettype none
// ============================================================================
// Module  : zigzag_row_walker
// Purpose : Incremental rail index for a zigzag walk over K rails (no divider).
// Revision: 1.0
// ============================================================================
module zigzag_row_walker
  import zigzag_pkg::*;
#(
  parameter int ROW_BITS = ROW_W,
  parameter int K_BITS   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                step,
  input  logic [K_BITS-1:0]   K,
  output logic [ROW_BITS-1:0] row,
  output logic                dir
);

  logic [ROW_BITS-1:0] r_row;
  logic                r_dir;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_row <= '0;
      r_dir <= 1'b0;
    end else if (step && (K > K_BITS'(1))) begin
      if (!r_dir) begin
        r_row <= r_row + ROW_BITS'(1);
        if ((K_BITS'(r_row) + K_BITS'(1)) == (K - K_BITS'(1)))
          r_dir <= 1'b1;
      end else begin
        r_row <= r_row - ROW_BITS'(1);
        if (r_row == ROW_BITS'(1))
          r_dir <= 1'b0;
      end
    end
  end

  assign row = r_row;
  assign dir = r_dir;

endmodule
`default_nettype wire

// File: rtl/zigzag_decryption_gen.sv
`default_nettype none
// ============================================================================
// Module  : zigzag_decryption_gen
// Purpose : Rail-fence decryptor: buffer ciphertext, size rails, stream plaintext.
// Revision: 1.0
// ============================================================================
module zigzag_decryption_gen
  import zigzag_pkg::*;
#(
  parameter int                D_WIDTH                = 8,
  parameter int                KEY_WIDTH              = 16,
  parameter int                MAX_NOF_CHARS          = 50,
  parameter int                MAX_KEY                = 8,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 overflow_o,
  output logic                 key_err_o
);

  localparam int POS_BITS = pos_w_of(MAX_NOF_CHARS);
  localparam int ROW_BITS = row_w_of(MAX_KEY);
  localparam int K_BITS   = $clog2(MAX_KEY + 1);

  state_t r_state;
  state_t w_next;

  logic [D_WIDTH-1:0]  r_buf   [MAX_NOF_CHARS];
  logic [POS_BITS-1:0] r_cnt   [MAX_KEY];
  logic [POS_BITS-1:0] r_start [MAX_KEY];
  logic [POS_BITS-1:0] r_ptr   [MAX_KEY];
  logic [POS_BITS-1:0] w_start [MAX_KEY];

  logic [POS_BITS-1:0] r_n;
  logic [POS_BITS-1:0] r_pos;
  logic [K_BITS-1:0]   r_k;
  logic [D_WIDTH-1:0]  r_data;
  logic                r_valid;
  logic                r_ovf;
  logic                r_kerr;

  logic [ROW_BITS-1:0] w_row;
  logic [POS_BITS-1:0] w_addr;
  logic                w_is_token;
  logic                w_has_room;
  logic                w_store;
  logic                w_token_accept;
  logic                w_last_pos;
  logic                w_key_big;

  assign w_is_token     = (data_i == START_DECRYPTION_TOKEN);
  assign w_has_room     = (r_n < POS_BITS'(MAX_NOF_CHARS));
  assign w_store        = (r_state == COLLECT) && valid_i && !w_is_token && w_has_room;
  assign w_token_accept = (r_state == COLLECT) && valid_i && w_is_token && (r_n != '0);
  assign w_last_pos     = (r_pos == (r_n - POS_BITS'(1)));
  assign w_key_big      = (32'(key) > 32'(MAX_KEY));
  assign w_addr         = r_start[w_row] + r_ptr[w_row];

  zigzag_row_walker #(
    .ROW_BITS (ROW_BITS),
    .K_BITS   (K_BITS)
  ) u_walker (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_token_accept || (r_state == OFFSET)),
    .step  ((r_state == COUNT) || (r_state == EMIT)),
    .K     (r_k),
    .row   (w_row),
    .dir   ()
  );

  // Exclusive prefix sum of rail lengths gives each rail's first buffer slot.
  always_comb begin
    logic [POS_BITS-1:0] v_acc;
    v_acc = '0;
    for (int r = 0; r < MAX_KEY; r++) begin
      w_start[r] = v_acc;
      v_acc      = v_acc + r_cnt[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= COLLECT;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      COLLECT: if (w_token_accept) w_next = COUNT;
      COUNT:   if (w_last_pos)     w_next = OFFSET;
      OFFSET:                      w_next = EMIT;
      EMIT:    if (w_last_pos)     w_next = DONE;
      DONE:                        w_next = COLLECT;
      default:                     w_next = COLLECT;
    endcase
  end

  always_comb begin
    busy = (r_state != COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_store)
      r_buf[r_n] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n     <= '0;
      r_pos   <= '0;
      r_k     <= K_BITS'(1);
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_kerr  <= 1'b0;
      for (int r = 0; r < MAX_KEY; r++) begin
        r_cnt[r]   <= '0;
        r_start[r] <= '0;
        r_ptr[r]   <= '0;
      end
    end else begin
      r_kerr <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_store)
            r_n <= r_n + POS_BITS'(1);
          else if (valid_i && !w_is_token)
            r_ovf <= 1'b1;
          if (w_token_accept) begin
            r_k    <= K_BITS'(eff_key(32'(key), MAX_KEY));
            r_kerr <= w_key_big;
            r_pos  <= '0;
            for (int r = 0; r < MAX_KEY; r++)
              r_cnt[r] <= '0;
          end
        end
        COUNT: begin
          r_cnt[w_row] <= r_cnt[w_row] + POS_BITS'(1);
          r_pos        <= r_pos + POS_BITS'(1);
        end
        OFFSET: begin
          r_start <= w_start;
          r_pos   <= '0;
          for (int r = 0; r < MAX_KEY; r++)
            r_ptr[r] <= '0;
        end
        EMIT: begin
          r_data       <= r_buf[w_addr];
          r_valid      <= 1'b1;
          r_ptr[w_row] <= r_ptr[w_row] + POS_BITS'(1);
          r_pos        <= r_pos + POS_BITS'(1);
        end
        DONE: begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_n     <= '0;
          r_ovf   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign data_o     = r_data;
  assign valid_o    = r_valid;
  assign overflow_o = r_ovf;
  assign key_err_o  = r_kerr;

endmodule
`default_nettype wire

// File: tb/tb_zigzag_decryption_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_zigzag_decryption_gen
// Purpose : Directed self-checking bench for the zigzag decryptor.
// Revision: 1.0
// ============================================================================
module tb_zigzag_decryption_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [15:0] key;
  logic        busy;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        overflow_o;
  logic        key_err_o;

  int tests = 0;
  int fails = 0;

  zigzag_decryption_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .key        (key),
    .busy       (busy),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .overflow_o (overflow_o),
    .key_err_o  (key_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
    end
  endtask

  // Forward rail-fence encryption, used only to build the long overflow vector.
  function automatic string rail_encrypt(input string p, input int k);
    string s;
    int    l;
    s = "";
    l = 2 * (k - 1);
    for (int r = 0; r < k; r++)
      for (int i = 0; i < p.len(); i++) begin
        int m;
        int row;
        m   = i % l;
        row = (m >= k) ? (l - m) : m;
        if (row == r) s = $sformatf("%s%c", s, p[i]);
      end
    return s;
  endfunction

  task automatic send_chars(input string s);
    for (int i = 0; i < s.len(); i++) begin
      data_i  = s[i];
      valid_i = 1'b1;
      tick();
    end
    valid_i = 1'b0;
  endtask

  // Issues the token and tracks the whole decode against the expected timing.
  task automatic decode(input string tag, input int k, input string plain,
                        input bit kerr, input bit noise);
    int    n;
    int    first;
    int    low;
    int    nval;
    int    c;
    string got;
    n     = plain.len();
    first = -1;
    low   = -1;
    nval  = 0;
    got   = "";
    data_i  = 8'hFA;
    key     = 16'(k);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    c = 1;
    while (c <= 4 * n + 20) begin
      if (c == 1) check({tag, " key_err"}, 32'(key_err_o), 32'(kerr));
      if (c == 2) check({tag, " key_err_pulse"}, 32'(key_err_o), 0);
      if (!busy) begin
        low = c;
        break;
      end
      if (valid_o) begin
        if (first < 0) first = c;
        nval++;
        got = $sformatf("%s%c", got, data_o);
      end
      if (noise) begin
        valid_i = 1'b1;
        data_i  = (c % 2 == 1) ? 8'hFA : 8'h51;
      end
      tick();
      c++;
    end
    valid_i = 1'b0;
    check({tag, " first_valid"}, first, n + 3);
    check({tag, " busy_low"}, low, 2 * n + 3);
    check({tag, " valid_count"}, nval, n);
    check_str({tag, " text"}, got, plain);
    check({tag, " done_valid"}, 32'(valid_o), 0);
    check({tag, " done_data"}, 32'(data_o), 0);
    check({tag, " done_overflow"}, 32'(overflow_o), 0);
  endtask

  initial begin
    string plain50;
    string cipher50;
    int    seen;
    rst_n   = 1'b0;
    data_i  = 8'h00;
    valid_i = 1'b0;
    key     = 16'd0;
    repeat (3) tick();
    check("reset busy", 32'(busy), 0);
    check("reset valid", 32'(valid_o), 0);
    check("reset data", 32'(data_o), 0);
    check("reset overflow", 32'(overflow_o), 0);
    check("reset key_err", 32'(key_err_o), 0);
    rst_n = 1'b1;
    tick();

    send_chars("WECRLTEERDSOEEFEAOCAIVDEN");
    decode("k3", 3, "WEAREDISCOVEREDFLEEATONCE", 1'b0, 1'b0);
    send_chars("AGBFHCED");
    decode("k4", 4, "ABCDEFGH", 1'b0, 1'b0);
    send_chars("HLOEL");
    decode("k2", 2, "HELLO", 1'b0, 1'b0);
    send_chars("ABC");
    decode("k1", 1, "ABC", 1'b0, 1'b0);
    send_chars("ABC");
    decode("k0", 0, "ABC", 1'b0, 1'b0);
    send_chars("ABC");
    decode("k9", 9, "ABC", 1'b1, 1'b0);
    send_chars("XYZ");
    decode("k5", 5, "XYZ", 1'b0, 1'b0);

    // Overflow: 52 characters offered, the last two must be dropped.
    plain50  = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwx";
    cipher50 = rail_encrypt(plain50, 2);
    send_chars(cipher50);
    check("ovf after 50", 32'(overflow_o), 0);
    send_chars("!");
    check("ovf after 51", 32'(overflow_o), 1);
    send_chars("?");
    check("ovf after 52", 32'(overflow_o), 1);
    decode("ovf k2", 2, plain50, 1'b0, 1'b1);

    // Token with an empty buffer must not start anything.
    data_i  = 8'hFA;
    key     = 16'd2;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    seen = 0;
    repeat (6) begin
      if (busy || valid_o) seen++;
      tick();
    end
    check("empty token activity", seen, 0);

    // Reset in the middle of EMIT aborts the decode.
    send_chars("AGBFHCED");
    data_i  = 8'hFA;
    key     = 16'd4;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    seen = 0;
    while (!valid_o && seen < 40) begin
      tick();
      seen++;
    end
    check("abort reached emit", 32'(valid_o), 1);
    tick();
    rst_n = 1'b0;
    tick();
    check("abort valid", 32'(valid_o), 0);
    check("abort busy", 32'(busy), 0);
    check("abort data", 32'(data_o), 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      if (valid_o || busy) seen++;
    end
    check("abort quiet", seen, 0);
    send_chars("HLOEL");
    decode("post-reset k2", 2, "HELLO", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
